// File: rtl/write_ptr_full.sv
`default_nettype none
//============================================================================
//  Module      : write_ptr_full
//  Description : Write-side pointer and flag logic for an asynchronous FIFO.
//                Keeps a binary and a Gray write pointer. It compares the
//                next Gray pointer with the synchronized read pointer to
//                produce a registered full flag. It also derives a
//                pessimistic occupancy estimate, an almost-full flag, and a
//                sticky overflow flag.
//
//  Parameters  : NUM_BITS - pointer width (address bits + 1 wrap bit);
//                           FIFO depth = 2**(NUM_BITS-1)
//                AF_LEVEL - occupancy at or above which almost_full asserts
//                           (1 .. 2**(NUM_BITS-1))
//
//  Ports       : wr_clk          in   write-domain clock
//                wr_rst          in   asynchronous active-low reset
//                wr_en           in   write request from the producer
//                ovf_clr         in   synchronous clear of overflow
//                r_ptr_gray_sync in   read pointer (Gray), wr_clk domain
//                wr_ptr_bin      out  registered binary write pointer
//                wr_ptr_gray     out  registered Gray write pointer
//                wr_addr         out  RAM write address
//                mem_we          out  RAM write strobe (combinational)
//                full            out  registered full flag
//                almost_full     out  registered almost-full flag
//                wr_level        out  registered occupancy estimate
//                overflow        out  sticky write-while-full flag
//
//  Revision    : 1.0 - initial release
//============================================================================
module write_ptr_full #(
    parameter int NUM_BITS = 4,
    parameter int AF_LEVEL = 6
) (
    input  logic                wr_clk,
    input  logic                wr_rst,
    input  logic                wr_en,
    input  logic                ovf_clr,
    input  logic [NUM_BITS-1:0] r_ptr_gray_sync,
    output logic [NUM_BITS-1:0] wr_ptr_bin,
    output logic [NUM_BITS-1:0] wr_ptr_gray,
    output logic [NUM_BITS-2:0] wr_addr,
    output logic                mem_we,
    output logic                full,
    output logic                almost_full,
    output logic [NUM_BITS-1:0] wr_level,
    output logic                overflow
);

    // The write pointer is exactly one depth ahead of the read pointer when
    // the two top Gray bits differ and all lower bits match. XOR-ing the read
    // Gray pointer with this mask gives the value that means "full".
    localparam logic [NUM_BITS-1:0] c_FULL_MASK = ~({NUM_BITS{1'b1}} >> 2);
    localparam logic [NUM_BITS-1:0] c_AF_LEVEL  = AF_LEVEL[NUM_BITS-1:0];

    // Registered state
    logic [NUM_BITS-1:0] r_bin;
    logic [NUM_BITS-1:0] r_gray;
    logic [NUM_BITS-1:0] r_level;
    logic                r_full;
    logic                r_af;
    logic                r_ovf;

    // Next-state logic
    logic                w_push;
    logic                w_ovf_set;
    logic [NUM_BITS-1:0] w_bin_nxt;
    logic [NUM_BITS-1:0] w_gray_nxt;
    logic [NUM_BITS-1:0] w_r_bin;
    logic [NUM_BITS-1:0] w_lvl_nxt;
    logic                w_full_nxt;
    logic                w_af_nxt;

    // A write is accepted only while not full. A write attempted while full
    // is dropped and recorded in the sticky overflow flag.
    assign w_push    = wr_en & ~r_full;
    assign w_ovf_set = wr_en &  r_full;

    // The pointer wraps naturally modulo 2**NUM_BITS.
    assign w_bin_nxt  = r_bin + {{(NUM_BITS-1){1'b0}}, w_push};
    assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);

    // Gray-to-binary: bit i is the XOR of all Gray bits from i up to the MSB.
    for (genvar i = 0; i < NUM_BITS; i++) begin : g_g2b
        assign w_r_bin[i] = ^(r_ptr_gray_sync >> i);
    end

    // Full and level use the look-ahead pointer, so full asserts on the
    // same edge that consumes the last free slot. Both flags are released
    // only when the synchronized read pointer actually moves.
    assign w_full_nxt = (w_gray_nxt == (r_ptr_gray_sync ^ c_FULL_MASK));
    assign w_lvl_nxt  = w_bin_nxt - w_r_bin;
    assign w_af_nxt   = (w_lvl_nxt >= c_AF_LEVEL);

    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            r_bin   <= '0;
            r_gray  <= '0;
            r_level <= '0;
            r_full  <= 1'b0;
            r_af    <= 1'b0;
        end else begin
            r_bin   <= w_bin_nxt;
            r_gray  <= w_gray_nxt;
            r_level <= w_lvl_nxt;
            r_full  <= w_full_nxt;
            r_af    <= w_af_nxt;
        end
    end

    // Set has priority over clear so a simultaneous overflow is not lost.
    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign wr_ptr_bin  = r_bin;
    assign wr_ptr_gray = r_gray;
    assign wr_addr     = r_bin[NUM_BITS-2:0];
    assign mem_we      = w_push;
    assign full        = r_full;
    assign almost_full = r_af;
    assign wr_level    = r_level;
    assign overflow    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_write_ptr_full.sv
`default_nettype none
//============================================================================
//  Module      : tb_write_ptr_full
//  Description : Self-checking bench for write_ptr_full (NUM_BITS=4,
//                AF_LEVEL=6). The reference model tracks unbounded write and
//                read counts. Occupancy is their difference. Pointers are the
//                counts taken modulo 16.
//  Revision    : 1.0 - initial release
//============================================================================
module tb_write_ptr_full;

    localparam int NB    = 4;
    localparam int DEPTH = 8;
    localparam int AF    = 6;

    logic          wr_clk;
    logic          wr_rst;
    logic          wr_en;
    logic          ovf_clr;
    logic [NB-1:0] r_ptr_gray_sync;
    logic [NB-1:0] wr_ptr_bin;
    logic [NB-1:0] wr_ptr_gray;
    logic [NB-2:0] wr_addr;
    logic          mem_we;
    logic          full;
    logic          almost_full;
    logic [NB-1:0] wr_level;
    logic          overflow;

    write_ptr_full #(.NUM_BITS(NB), .AF_LEVEL(AF)) dut (
        .wr_clk          (wr_clk),
        .wr_rst          (wr_rst),
        .wr_en           (wr_en),
        .ovf_clr         (ovf_clr),
        .r_ptr_gray_sync (r_ptr_gray_sync),
        .wr_ptr_bin      (wr_ptr_bin),
        .wr_ptr_gray     (wr_ptr_gray),
        .wr_addr         (wr_addr),
        .mem_we          (mem_we),
        .full            (full),
        .almost_full     (almost_full),
        .wr_level        (wr_level),
        .overflow        (overflow)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int m_wr;      // total accepted writes since reset
    int m_rd;      // total reads reflected in r_ptr_gray_sync
    bit m_full;
    bit m_ovf;

    function automatic logic [NB-1:0] to_gray(input int cnt);
        logic [NB-1:0] b;
        b = NB'(cnt % 16);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        int occ;
        occ = m_wr - m_rd;
        chk({tag, ":wr_ptr_bin"},  32'(wr_ptr_bin),  32'(m_wr % 16));
        chk({tag, ":wr_ptr_gray"}, 32'(wr_ptr_gray), 32'(to_gray(m_wr)));
        chk({tag, ":wr_addr"},     32'(wr_addr),     32'(m_wr % DEPTH));
        chk({tag, ":wr_level"},    32'(wr_level),    32'(occ));
        chk({tag, ":full"},        32'(full),        32'(occ == DEPTH));
        chk({tag, ":almost_full"}, 32'(almost_full), 32'(occ >= AF));
        chk({tag, ":overflow"},    32'(overflow),    32'(m_ovf));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ":wr_ptr_bin"},  32'(wr_ptr_bin),  32'd0);
        chk({tag, ":wr_ptr_gray"}, 32'(wr_ptr_gray), 32'd0);
        chk({tag, ":wr_level"},    32'(wr_level),    32'd0);
        chk({tag, ":full"},        32'(full),        32'd0);
        chk({tag, ":almost_full"}, 32'(almost_full), 32'd0);
        chk({tag, ":overflow"},    32'(overflow),    32'd0);
    endtask

    // One clock cycle. It is entered 1 time unit after a rising edge. It
    // applies the inputs, checks the combinational strobe, clocks once,
    // advances the model, and checks the registered outputs.
    task automatic cycle(input string tag, input bit we, input bit clr, input int rd_cnt);
        bit push;
        wr_en           = we;
        ovf_clr         = clr;
        m_rd            = rd_cnt;
        r_ptr_gray_sync = to_gray(rd_cnt);
        #1;
        push = we && !m_full;
        chk({tag, ":mem_we"}, 32'(mem_we), 32'(push));
        @(posedge wr_clk);
        #1;
        if (we && m_full)  m_ovf = 1'b1;
        else if (clr)      m_ovf = 1'b0;
        if (push) m_wr++;
        m_full = ((m_wr - m_rd) == DEPTH);
        check_outputs(tag);
    endtask

    task automatic model_reset();
        m_wr   = 0;
        m_rd   = 0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p_we;
        int rd_next;

        // Power-on reset
        wr_rst          = 1'b0;
        wr_en           = 1'b0;
        ovf_clr         = 1'b0;
        r_ptr_gray_sync = '0;
        model_reset();
        #1;
        check_zero("por");
        @(posedge wr_clk);
        @(posedge wr_clk);
        #1;
        wr_rst = 1'b1;

        // Fill: eight writes against a stationary read pointer
        for (int i = 1; i <= DEPTH; i++) begin
            cycle("fill", 1'b1, 1'b0, 0);
            if (i == AF) chk("fill:af_at_6", 32'(almost_full), 32'd1);
        end
        chk("fill:gray_full", 32'(wr_ptr_gray), 32'b1100);
        chk("fill:level8",    32'(wr_level),    32'd8);

        // Overflow: write while full, then clear with and without a write
        cycle("ovf_set", 1'b1, 1'b0, 0);
        chk("ovf_set:ptr_held", 32'(wr_ptr_bin), 32'd8);
        cycle("ovf_setwins", 1'b1, 1'b1, 0);
        chk("ovf_setwins:ovf", 32'(overflow), 32'd1);
        cycle("ovf_clr", 1'b0, 1'b1, 0);
        chk("ovf_clr:ovf", 32'(overflow), 32'd0);

        // Release: the read pointer moves away from full
        cycle("rel1", 1'b0, 1'b0, 1);
        chk("rel1:level7", 32'(wr_level), 32'd7);
        cycle("rel2", 1'b0, 1'b0, 2);
        chk("rel2:level6", 32'(wr_level), 32'd6);

        // Simultaneous push and read advance at level 5
        cycle("to5", 1'b0, 1'b0, 3);
        cycle("simul", 1'b1, 1'b0, 4);
        chk("simul:level5", 32'(wr_level), 32'd5);
        chk("simul:af0",    32'(almost_full), 32'd0);

        // Wrap: stream writes with the read count trailing by two
        cycle("trail", 1'b0, 1'b0, m_wr - 2);
        for (int i = 0; i < 12; i++) begin
            cycle("wrap", 1'b1, 1'b0, m_wr - 1);
            chk("wrap:level2", 32'(wr_level), 32'd2);
        end

        // Randomized traffic with alternating write pressure
        for (int i = 0; i < 600; i++) begin
            p_we    = ((i / 60) % 2 == 0) ? 85 : 30;
            rd_next = m_rd;
            if ($urandom_range(0, 99) < 50 && m_rd < m_wr) rd_next = m_rd + 1;
            cycle("rand", ($urandom_range(0, 99) < p_we), ($urandom_range(0, 7) == 0), rd_next);
        end

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 3; i++) cycle("burst", 1'b1, 1'b0, m_rd);
        #2;
        wr_rst = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        r_ptr_gray_sync = '0;
        @(posedge wr_clk);
        #1;
        check_zero("hold_rst");
        wr_rst = 1'b1;
        cycle("post_rst", 1'b1, 1'b0, 0);
        chk("post_rst:ptr1", 32'(wr_ptr_bin), 32'd1);
        cycle("post_idle", 1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
